// File: rtl/uar_bit_recovery.sv
// uar_bit_recovery: multi-channel UART receive front end.
// Shared oversample tick, 2-flop sync, majority-vote bit recovery.
// Ports: clk_in, rst_n_in (sync, active low); sig_in serial lines;
//   bit_valid_out/bit_out data-bit strobe and value; busy_out;
//   start_err_out false start; frame_done_out/frame_err_out stop status.
module uar_bit_recovery #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int BAUD_RATE    = 9600,
  parameter int SAMP_PER_BIT = 16,
  parameter int NUM_CH       = 1,
  parameter int VOTE_TAPS    = 3,
  parameter int DATA_BITS    = 8
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [NUM_CH-1:0] sig_in,
  output logic [NUM_CH-1:0] bit_valid_out,
  output logic [NUM_CH-1:0] bit_out,
  output logic [NUM_CH-1:0] busy_out,
  output logic [NUM_CH-1:0] start_err_out,
  output logic [NUM_CH-1:0] frame_done_out,
  output logic [NUM_CH-1:0] frame_err_out
);

  localparam int DIV = CLK_HZ / (SAMP_PER_BIT * BAUD_RATE);
  localparam int TW  = $clog2(DIV) + 1;
  localparam int SW  = $clog2(SAMP_PER_BIT);
  localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int DP  = SAMP_PER_BIT / 2 + (VOTE_TAPS - 1) / 2;

  localparam logic [TW-1:0] TICK_LD = TW'(DIV - 1);
  localparam logic [SW-1:0] S_DEC   = SW'(DP);
  localparam logic [SW-1:0] S_LAST  = SW'(SAMP_PER_BIT - 1);
  localparam logic [BW-1:0] B_LAST  = BW'(DATA_BITS - 1);
  localparam logic [3:0]    MAJ     = 4'(VOTE_TAPS / 2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  logic [TW-1:0] r_tick_cnt;
  logic          w_tick;

  assign w_tick = (r_tick_cnt == '0);

  always_ff @(posedge clk_in) begin
    if (!rst_n_in)   r_tick_cnt <= TICK_LD;
    else if (w_tick) r_tick_cnt <= TICK_LD;
    else             r_tick_cnt <= r_tick_cnt - 1'b1;
  end

  logic [NUM_CH-1:0] r_sync1;
  logic [NUM_CH-1:0] r_sync2;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= sig_in;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t               r_state;
    state_t               w_state_n;
    logic [SW-1:0]        r_samp;
    logic [SW-1:0]        w_samp_n;
    logic [SW-1:0]        w_samp_inc;
    logic [BW-1:0]        r_bit;
    logic [BW-1:0]        w_bit_n;
    logic [VOTE_TAPS-1:0] w_win;
    logic [3:0]           w_ones;
    logic                 w_s;
    logic                 w_maj;
    logic                 w_at_dec;
    logic                 r_bv, r_bo, r_busy;
    logic                 r_serr, r_done, r_ferr;
    logic                 w_bv_n, w_bo_n;
    logic                 w_serr_n, w_done_n, w_ferr_n;

    assign w_s        = r_sync2[c];
    assign w_samp_inc = (r_samp == S_LAST) ? '0 : r_samp + 1'b1;
    assign w_at_dec   = (r_samp == S_DEC);

    // Window = previous VOTE_TAPS-1 tick samples plus the live one,
    // so the vote at index D is centred on mid-bit.
    if (VOTE_TAPS > 1) begin : g_hist
      logic [VOTE_TAPS-2:0] r_hist;
      always_ff @(posedge clk_in) begin
        if (!rst_n_in)   r_hist <= '1;
        else if (w_tick) r_hist <= w_win[VOTE_TAPS-2:0];
      end
      assign w_win = {r_hist, w_s};
    end else begin : g_nohist
      assign w_win = w_s;
    end

    always_comb begin
      w_ones = '0;
      for (int i = 0; i < VOTE_TAPS; i++)
        w_ones = w_ones + {3'b000, w_win[i]};
    end

    assign w_maj = (w_ones > MAJ);

    always_comb begin
      w_state_n = r_state;
      w_samp_n  = r_samp;
      w_bit_n   = r_bit;
      w_bv_n    = 1'b0;
      w_bo_n    = r_bo;
      w_serr_n  = 1'b0;
      w_done_n  = 1'b0;
      w_ferr_n  = 1'b0;
      if (w_tick) begin
        unique case (r_state)
          ST_IDLE: begin
            // the tick that saw 0 is sample 0 of the start bit
            if (!w_s) begin
              w_state_n = ST_START;
              w_samp_n  = SW'(1);
            end
          end
          ST_START: begin
            w_samp_n = w_samp_inc;
            if (w_at_dec) begin
              if (w_maj) begin
                w_state_n = ST_IDLE;
                w_samp_n  = '0;
                w_serr_n  = 1'b1;
              end else begin
                w_state_n = ST_DATA;
                w_bit_n   = '0;
              end
            end
          end
          ST_DATA: begin
            w_samp_n = w_samp_inc;
            if (w_at_dec) begin
              w_bv_n = 1'b1;
              w_bo_n = w_maj;
              if (r_bit == B_LAST) w_state_n = ST_STOP;
              else                 w_bit_n   = r_bit + 1'b1;
            end
          end
          ST_STOP: begin
            w_samp_n = w_samp_inc;
            // leave at mid-stop so the next edge can resync
            if (w_at_dec) begin
              w_state_n = ST_IDLE;
              w_samp_n  = '0;
              w_done_n  = 1'b1;
              w_ferr_n  = ~w_maj;
            end
          end
          default: w_state_n = ST_IDLE;
        endcase
      end
    end

    always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
        r_state <= ST_IDLE;
        r_samp  <= '0;
        r_bit   <= '0;
        r_bv    <= 1'b0;
        r_bo    <= 1'b0;
        r_busy  <= 1'b0;
        r_serr  <= 1'b0;
        r_done  <= 1'b0;
        r_ferr  <= 1'b0;
      end else begin
        r_state <= w_state_n;
        r_samp  <= w_samp_n;
        r_bit   <= w_bit_n;
        r_bv    <= w_bv_n;
        r_bo    <= w_bo_n;
        r_busy  <= (w_state_n != ST_IDLE);
        r_serr  <= w_serr_n;
        r_done  <= w_done_n;
        r_ferr  <= w_ferr_n;
      end
    end

    assign bit_valid_out[c]  = r_bv;
    assign bit_out[c]        = r_bo;
    assign busy_out[c]       = r_busy;
    assign start_err_out[c]  = r_serr;
    assign frame_done_out[c] = r_done;
    assign frame_err_out[c]  = r_ferr;
  end

endmodule
